// File: rtl/tone_gen.sv
// Square-wave tone generator: counts up from a divider preset to all-ones, toggling SPKS at each wrap.
// Latency: a preset accepted while idle starts on the next edge; while playing it lands at the next half-period boundary.
// Backpressure: TO_RDY drops while the one-entry pending slot is full; the producer holds TO and TO_VLD.
`timescale 1ns/1ps
module tone_gen #(
    parameter int WIDTH = 11
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] TO,
    input  logic             TO_VLD,
    output logic             TO_RDY,
    output logic             SPKS,
    output logic             TICK,
    output logic             ACTIVE
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act;
    logic [WIDTH-1:0] pend;
    logic             pend_f;
    logic             spks_q;

    logic             boundary;
    logic             pend_rest;
    logic             accept;
    logic             consume;

    always_comb begin
        boundary  = (state == RUN) && (cnt == ALL_ONES);
        pend_rest = (pend == ALL_ONES);
        accept    = TO_VLD && !pend_f;
        consume   = pend_f && ((state == IDLE) || boundary);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend_f && !pend_rest) state_nxt = RUN;
            RUN:     if (boundary && pend_f && pend_rest) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // accept and consume are mutually exclusive: accept needs the slot empty, consume needs it full
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= ALL_ONES;
            act    <= ALL_ONES;
            pend   <= '0;
            pend_f <= 1'b0;
            spks_q <= 1'b0;
        end else begin
            if (accept) begin
                pend   <= TO;
                pend_f <= 1'b1;
            end else if (consume) begin
                pend_f <= 1'b0;
            end

            if (consume) begin
                act <= pend;
            end

            if (state == IDLE) begin
                spks_q <= 1'b0;
                if (pend_f) begin
                    cnt <= pend;
                end
            end else if (boundary) begin
                cnt    <= pend_f ? pend : act;
                // a rest preset parks the speaker low rather than leaving it mid-level
                spks_q <= (pend_f && pend_rest) ? 1'b0 : ~spks_q;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

    always_comb begin
        TO_RDY = ~pend_f;
        TICK   = boundary;
        ACTIVE = (state == RUN);
        SPKS   = spks_q;
    end

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: half-period table, hand-written corner sequences and a randomized run
// compared every cycle against a countdown model of the tone rules.
`timescale 1ns/1ps
module tb_tone_gen;

    localparam int W    = 11;
    localparam int FULL = 1 << W;
    localparam int REST = FULL - 1;

    logic         CLK    = 1'b0;
    logic         RST_N  = 1'b0;
    logic [W-1:0] TO     = '0;
    logic         TO_VLD = 1'b0;
    logic         TO_RDY;
    logic         SPKS;
    logic         TICK;
    logic         ACTIVE;

    tone_gen #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .TO     (TO),
        .TO_VLD (TO_VLD),
        .TO_RDY (TO_RDY),
        .SPKS   (SPKS),
        .TICK   (TICK),
        .ACTIVE (ACTIVE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: remaining cycles in the current half-period, and a queue for the pending slot
    bit playing = 1'b0;
    bit spk     = 1'b0;
    int rem     = 0;
    int cur     = 0;
    int pq[$];
    int ticks[$];
    int run_len = 0;
    int min_run = 1 << 30;
    logic prev_spks = 1'b0;

    typedef struct {
        logic [W-1:0] preset;
        int           exp_half;
        bit           exp_active;
    } vec_t;

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            playing = 1'b0;
            spk     = 1'b0;
            rem     = 0;
            pq.delete();
        end else begin
            bit acc;
            int v;
            int p;
            acc = (TO_VLD === 1'b1) && (pq.size() == 0);
            v   = int'(TO);
            cyc++;
            if (!playing) begin
                if (pq.size() != 0) begin
                    p = pq.pop_front();
                    if (p != REST) begin
                        playing = 1'b1;
                        cur     = p;
                        rem     = FULL - p;
                    end
                end
            end else if (rem == 1) begin
                if (pq.size() != 0) begin
                    p = pq.pop_front();
                    if (p == REST) begin
                        playing = 1'b0;
                        spk     = 1'b0;
                    end else begin
                        cur = p;
                        rem = FULL - p;
                        spk = !spk;
                    end
                end else begin
                    rem = FULL - cur;
                    spk = !spk;
                end
            end else begin
                rem--;
            end
            if (acc) pq.push_back(v);
        end
    end

    initial forever begin
        @(negedge CLK);
        check_bit("spks",   SPKS,   spk);
        check_bit("tick",   TICK,   playing && rem == 1);
        check_bit("active", ACTIVE, playing);
        check_bit("to_rdy", TO_RDY, pq.size() == 0);
        if (TICK === 1'b1) ticks.push_back(cyc);
        if (SPKS !== prev_spks) begin
            if (run_len < min_run) min_run = run_len;
            run_len = 1;
        end else begin
            run_len++;
        end
        prev_spks = SPKS;
    end

    task automatic step();
        @(negedge CLK);
        #2;
    endtask

    task automatic reset_outputs_check(input string tag);
        check_bit({tag, "_rdy"},    TO_RDY, 1'b1);
        check_bit({tag, "_spks"},   SPKS,   1'b0);
        check_bit({tag, "_tick"},   TICK,   1'b0);
        check_bit({tag, "_active"}, ACTIVE, 1'b0);
    endtask

    task automatic do_reset();
        RST_N  = 1'b0;
        TO_VLD = 1'b0;
        #1;
        reset_outputs_check("rst");
        step();
        step();
        RST_N = 1'b1;
        step();
    endtask

    task automatic send(input logic [W-1:0] p, output int acc_cyc, output int waits);
        bit rdy;
        bit done;
        done   = 1'b0;
        waits  = 0;
        TO     = p;
        TO_VLD = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            rdy = TO_RDY;
            step();
            if (rdy) begin
                done = 1'b1;
                break;
            end
            waits++;
        end
        TO_VLD  = 1'b0;
        acc_cyc = cyc;
        if (!done) fail_timeout("send");
    endtask

    task automatic wait_ticks(input int n, input int bound, input string name);
        int i;
        i = 0;
        while (ticks.size() < n && i < bound) begin
            step();
            i++;
        end
        if (ticks.size() < n) fail_timeout(name);
    endtask

    initial begin
        vec_t vecs[8];
        int   k;
        int   k2;
        int   w;
        int   w2;
        int   t0;

        vecs[0] = '{11'h7FE, 2,    1'b1};
        vecs[1] = '{11'h7FC, 4,    1'b1};
        vecs[2] = '{11'h7F8, 8,    1'b1};
        vecs[3] = '{11'h7F0, 16,   1'b1};
        vecs[4] = '{11'h7C0, 64,   1'b1};
        vecs[5] = '{11'h600, 512,  1'b1};
        vecs[6] = '{11'h000, 2048, 1'b1};
        vecs[7] = '{11'h7FF, 0,    1'b0};

        #1;
        reset_outputs_check("por");
        do_reset();

        // idle after reset
        ticks.delete();
        repeat (100) step();
        check_int("idle_ticks", ticks.size(), 0);
        check_bit("idle_spks",   SPKS,   1'b0);
        check_bit("idle_rdy",    TO_RDY, 1'b1);
        check_bit("idle_active", ACTIVE, 1'b0);

        // half-period table
        foreach (vecs[i]) begin
            do_reset();
            ticks.delete();
            send(vecs[i].preset, k, w);
            check_int("tbl_wait", w, 0);
            step();
            check_bit("tbl_active", ACTIVE, vecs[i].exp_active);
            if (vecs[i].exp_half > 0) begin
                wait_ticks(2, 3 * vecs[i].exp_half + 10, "tbl_ticks");
                if (ticks.size() >= 2) begin
                    check_int("tbl_latency", ticks[0] - k, vecs[i].exp_half);
                    check_int("tbl_half", ticks[1] - ticks[0], vecs[i].exp_half);
                end
            end else begin
                repeat (20) step();
                check_int("tbl_rest_ticks", ticks.size(), 0);
                check_bit("tbl_rest_active", ACTIVE, 1'b0);
            end
        end

        // preset change mid half-period waits for the boundary
        do_reset();
        ticks.delete();
        send(11'h7FC, k, w);
        wait_ticks(1, 50, "chg_first");
        t0 = (ticks.size() > 0) ? ticks[ticks.size() - 1] : cyc;
        step();
        ticks.delete();
        min_run = 1 << 30;
        send(11'h7F0, k, w);
        check_int("chg_wait", w, 0);
        check_bit("chg_rdy_low", TO_RDY, 1'b0);
        wait_ticks(1, 20, "chg_bnd");
        if (ticks.size() >= 1) check_int("chg_old_half", ticks[0] - t0, 4);
        check_bit("chg_rdy_at_bnd", TO_RDY, 1'b0);
        step();
        check_bit("chg_rdy_rise", TO_RDY, 1'b1);
        wait_ticks(3, 60, "chg_new");
        if (ticks.size() >= 3) begin
            check_int("chg_new_half1", ticks[1] - ticks[0], 16);
            check_int("chg_new_half2", ticks[2] - ticks[1], 16);
        end
        check_bit("chg_no_runt", min_run >= 4, 1'b1);

        // rest preset while running
        do_reset();
        ticks.delete();
        send(11'h7F8, k, w);
        wait_ticks(1, 40, "rest_first");
        step();
        check_bit("rest_spks_high", SPKS, 1'b1);
        send(11'h7FF, k, w);
        wait_ticks(2, 20, "rest_bnd");
        check_bit("rest_tick", TICK, 1'b1);
        step();
        check_bit("rest_spks",   SPKS,   1'b0);
        check_bit("rest_active", ACTIVE, 1'b0);
        repeat (30) step();
        check_int("rest_ticks", ticks.size(), 2);
        check_bit("rest_stay_idle", ACTIVE, 1'b0);

        // reset mid-run with a preset pending
        do_reset();
        ticks.delete();
        send(11'h7F8, k, w);
        wait_ticks(1, 40, "mrst_first");
        step();
        send(11'h7F0, k, w);
        step();
        check_bit("mrst_pend", TO_RDY, 1'b0);
        check_bit("mrst_running", ACTIVE, 1'b1);
        RST_N = 1'b0;
        #1;
        reset_outputs_check("mrst");
        step();
        step();
        RST_N = 1'b1;
        ticks.delete();
        repeat (40) step();
        check_int("mrst_ticks", ticks.size(), 0);
        check_bit("mrst_idle", ACTIVE, 1'b0);

        // back-to-back presets with TO_VLD held
        do_reset();
        ticks.delete();
        send(11'h7F8, k, w);
        send(11'h7FA, k2, w2);
        check_int("b2b_accept_gap", k2 - k, 2);
        check_int("b2b_wait", w2, 1);
        wait_ticks(3, 60, "b2b_ticks");
        if (ticks.size() >= 3) begin
            check_int("b2b_first_half", ticks[0] - k, 8);
            check_int("b2b_second_half1", ticks[1] - ticks[0], 6);
            check_int("b2b_second_half2", ticks[2] - ticks[1], 6);
        end

        // randomized presets, hold-until-ready producer, occasional async reset
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit rdy;
            if (!TO_VLD && $urandom_range(0, 2) == 0) begin
                TO_VLD = 1'b1;
                if ($urandom_range(0, 7) == 0) TO = 11'h7FF;
                else TO = 11'h7E0 + W'($urandom_range(0, 30));
            end
            if ($urandom_range(0, 599) == 0) begin
                RST_N  = 1'b0;
                TO_VLD = 1'b0;
                #1;
                reset_outputs_check("rnd_rst");
                step();
                step();
                RST_N = 1'b1;
            end
            rdy = TO_RDY;
            step();
            if (rdy) TO_VLD = 1'b0;
        end
        TO_VLD = 1'b0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 11, the divider preset width; all preset and counter arithmetic is WIDTH bits.
REQ-002 SHALL have port CLK  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port TO  input  WIDTH  divider preset from the note-code block; all-ones (0x7FF at default width) means rest.
REQ-005 SHALL have port TO_VLD  input  1  the TO value is valid this cycle.
REQ-006 SHALL have port TO_RDY  output  1  the block can accept a preset; a transfer occurs on a rising edge where TO_VLD=1 and TO_RDY=1.
REQ-007 SHALL have port SPKS  output  1  the square-wave speaker drive.
REQ-008 SHALL have port TICK  output  1  one-cycle pulse at each half-period boundary where SPKS toggles.
REQ-009 SHALL have port ACTIVE  output  1  high while a tone is playing (RUN state).

Function
REQ-010 SHALL hold these registers: CNT (counter), ACT (active preset), PEND plus PEND_F (a one-entry pending preset), STATE in {IDLE, RUN}, and SPKS.
REQ-011 SHALL drive TO_RDY = ~PEND_F combinationally, so a transfer is accepted only when PEND is empty.
REQ-012 SHALL, on a transfer, load PEND with TO and set PEND_F.
REQ-013 SHALL, in IDLE, hold CNT, keep SPKS=0, TICK=0 and ACTIVE=0.
REQ-014 SHALL, in IDLE with PEND_F=1 at an edge:
  - load ACT and CNT with PEND and clear PEND_F;
  - enter RUN if PEND != all-ones, otherwise stay in IDLE;
  - leave SPKS at 0 on entry.
REQ-015 SHALL, in RUN with CNT != all-ones, increment CNT by 1 each cycle; CNT never wraps through zero.
REQ-016 SHALL, in RUN with CNT == all-ones, treat the cycle as a boundary: TICK=1 (combinational in that cycle), SPKS toggles at the edge, and CNT reloads.
REQ-017 SHALL take the reload value at a boundary from PEND if PEND_F=1 (then ACT<=PEND and PEND_F cleared), otherwise from ACT.
REQ-018 SHALL, when the PEND value consumed at a boundary is all-ones:
  - go to IDLE;
  - force SPKS to 0 instead of toggling;
  - still assert TICK for that cycle.
REQ-019 SHALL give a half-period of (2^WIDTH - P) cycles for active preset P, and a full SPKS period of 2*(2^WIDTH - P):
  - P=0x7FE gives 2+2;
  - P=0x000 gives 2048+2048.
REQ-020 SHALL apply a preset change only at a boundary, never mid half-period, so SPKS has no runt pulses.
REQ-021 SHALL not accept a transfer in the same edge at which PEND is consumed, because TO_RDY was low; TO_RDY rises the cycle after consumption.
REQ-022 SHALL leave PEND, ACT and SPKS unaffected by TO_VLD while TO_RDY=0; the producer holds TO and TO_VLD.
REQ-023 SHALL drive ACTIVE = (STATE == RUN).

Reset
REQ-024 SHALL, when RST_N=0, immediately and asynchronously set:
  - STATE=IDLE;
  - CNT=all-ones and ACT=all-ones;
  - PEND_F=0, discarding any pending preset;
  - SPKS=0.
REQ-025 SHALL therefore present TO_RDY=1, TICK=0 and ACTIVE=0 during reset, including reset asserted mid-RUN.
REQ-026 SHALL resume normal operation on the first rising edge after RST_N deasserts, starting in IDLE.

Verification
REQ-027 SHALL cover: idle after reset, with no TO_VLD for 100 cycles -> SPKS=0, TO_RDY=1, ACTIVE=0, TICK never asserted.
REQ-028 SHALL cover: TO=0x7FE transferred at edge k -> RUN at k+1; TICK every 2 cycles; SPKS period 4 cycles at 50% duty.
REQ-029 SHALL cover: TO=0x7FC playing, then TO=0x7F0 presented mid half-period ->
  - TO_RDY low until the next boundary;
  - the old 4-cycle half-period completes;
  - afterwards half-period is 16 cycles;
  - no SPKS pulse shorter than 4 cycles.
REQ-030 SHALL cover: TO=0x7FF transferred while RUN -> at the next boundary TICK=1, SPKS=0, ACTIVE=0, and the block stays idle.
REQ-031 SHALL cover: RST_N pulsed low mid-RUN with PEND_F=1 -> outputs reset within the same cycle; after release the block idles and the pending preset is never played.
REQ-032 SHALL cover: two back-to-back presets 0x7F8 then 0x7FA with TO_VLD held ->
  - the first is accepted;
  - the second is held until TO_RDY rises the cycle after the first is consumed;
  - each is applied only at a boundary.
